// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: turns keypad codes into operand entry, ALU/multiplier scheduling and a
// result-history stack. Define CALC_SEQ_FAST_MUL_EN for a single-cycle combinational multiplier.
module calc_key_sequencer #(
    parameter int DEPTH      = 8,
    parameter int MUL_WIDTH  = 16,
    parameter int MAX_DIGITS = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             key,
    input  logic                   key_valid,
    output logic                   key_ready,
    output logic [31:0]            display,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] depth_used
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int PROD_W = 2 * MUL_WIDTH;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_SUB       = 4'd11;
    localparam logic [3:0] KEY_MUL       = 4'd12;
    localparam logic [3:0] KEY_EQ        = 4'd13;
    localparam logic [3:0] KEY_RECALL    = 4'd14;
    localparam logic [3:0] KEY_CLEAR     = 4'd15;

    localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DIGIT_MAX  = CNT_W'(MAX_DIGITS);

`ifdef CALC_SEQ_FAST_MUL_EN
    typedef enum logic [1:0] {ST_ENTRY, ST_EXEC_ALU} state_t;
`else
    localparam int MC_W = $clog2(MUL_WIDTH);
    typedef enum logic [1:0] {ST_ENTRY, ST_EXEC_ALU, ST_EXEC_MUL} state_t;
`endif

    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t             state;
    op_t                pending;
    op_t                op_next;
    logic               exec_eq;
    logic [31:0]        acc;
    logic [31:0]        prev;
    logic [CNT_W-1:0]   digit_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        stack [DEPTH];

`ifndef CALC_SEQ_FAST_MUL_EN
    logic [PROD_W-1:0]    mcand;
    logic [MUL_WIDTH-1:0] mplier;
    logic [PROD_W-1:0]    product;
    logic [MC_W-1:0]      mul_cnt;
    logic [PROD_W-1:0]    prod_next;
    logic                 mul_last;
`endif

    logic               accept;
    logic               is_op;
    logic               start_exec;
    logic [31:0]        acc_base;
    logic [31:0]        acc_digit;
    logic [32:0]        sum_ext;
    logic [32:0]        diff_ext;
    logic [31:0]        alu_result;
    logic               alu_ovf;
    logic               mul_range_ovf;
    logic               finish;
    logic [31:0]        fin_result;
    logic               fin_ovf;
    logic               push_en;
    logic [31:0]        push_val;
    logic [31:0]        rd_val;
    logic [PTR_W-1:0]   newest;
    logic [PTR_W-1:0]   oldest;

    assign key_ready = (state == ST_ENTRY);
    assign busy      = ~key_ready;
    assign accept    = key_valid && key_ready;
    assign is_op     = (key >= KEY_ADD) && (key <= KEY_MUL);

    function automatic op_t key_to_op(input logic [3:0] k);
        case (k)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            default: return OP_MUL;
        endcase
    endfunction

    always_comb begin
        // A zero digit count means the next digit starts a new operand, even if acc holds a result.
        acc_base      = (digit_cnt == '0) ? 32'd0 : acc;
        acc_digit     = acc_base * 32'd10 + {28'd0, key};
        sum_ext       = {1'b0, prev} + {1'b0, acc};
        diff_ext      = {1'b0, prev} - {1'b0, acc};
        mul_range_ovf = ((prev >> MUL_WIDTH) != 32'd0) || ((acc >> MUL_WIDTH) != 32'd0);
        alu_result    = sum_ext[31:0];
        alu_ovf       = sum_ext[32];
        case (pending)
            OP_SUB: begin
                alu_result = diff_ext[31:0];
                alu_ovf    = diff_ext[32];
            end
`ifdef CALC_SEQ_FAST_MUL_EN
            OP_MUL: begin
                alu_result = 32'(PROD_W'(prev[MUL_WIDTH-1:0]) * PROD_W'(acc[MUL_WIDTH-1:0]));
                alu_ovf    = mul_range_ovf;
            end
`endif
            default: ;
        endcase

        finish     = (state == ST_EXEC_ALU);
        fin_result = alu_result;
        fin_ovf    = alu_ovf;
`ifndef CALC_SEQ_FAST_MUL_EN
        prod_next = product + (mplier[0] ? mcand : '0);
        mul_last  = (mul_cnt == MC_W'(MUL_WIDTH - 1));
        if (state == ST_EXEC_MUL && mul_last) begin
            finish     = 1'b1;
            fin_result = 32'(prod_next);
            fin_ovf    = mul_range_ovf;
        end
`endif

        start_exec = (state == ST_ENTRY) && accept && (pending != OP_NONE) &&
                     ((key == KEY_EQ) || is_op);
        push_en    = (finish && exec_eq) ||
                     ((state == ST_ENTRY) && accept && (key == KEY_EQ) && (pending == OP_NONE));
        push_val   = finish ? fin_result : acc;

        rd_val = stack[rd_ptr];
        newest = wr_ptr - PTR_W'(1);
        oldest = wr_ptr - depth_used[PTR_W-1:0];
    end

    // History storage is not reset; depth_used alone decides which entries are valid.
    always_ff @(posedge clock) begin
        if (reset && push_en) begin
            stack[wr_ptr] <= push_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_ENTRY;
            pending    <= OP_NONE;
            op_next    <= OP_NONE;
            exec_eq    <= 1'b0;
            acc        <= '0;
            prev       <= '0;
            display    <= '0;
            overflow   <= 1'b0;
            digit_cnt  <= '0;
            depth_used <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
`ifndef CALC_SEQ_FAST_MUL_EN
            mcand      <= '0;
            mplier     <= '0;
            product    <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rd_ptr <= wr_ptr;
                if (depth_used != DEPTH_FULL) begin
                    depth_used <= depth_used + (PTR_W + 1)'(1);
                end
            end

            case (state)
                ST_ENTRY: begin
                    if (accept) begin
                        if (key <= KEY_DIGIT_MAX) begin
                            if (digit_cnt < DIGIT_MAX) begin
                                acc       <= acc_digit;
                                display   <= acc_digit;
                                digit_cnt <= digit_cnt + CNT_W'(1);
                            end
                        end else if (key == KEY_EQ) begin
                            digit_cnt <= '0;
                            exec_eq   <= 1'b1;
                            if (pending == OP_NONE) begin
                                display <= acc;
                            end
                        end else if (key == KEY_RECALL) begin
                            digit_cnt <= DIGIT_MAX;
                            if (depth_used == '0) begin
                                acc     <= '0;
                                display <= '0;
                            end else begin
                                acc     <= rd_val;
                                display <= rd_val;
                                rd_ptr  <= (rd_ptr == oldest) ? newest : rd_ptr - PTR_W'(1);
                            end
                        end else if (key == KEY_CLEAR) begin
                            acc       <= '0;
                            prev      <= '0;
                            display   <= '0;
                            overflow  <= 1'b0;
                            digit_cnt <= '0;
                            pending   <= OP_NONE;
                        end else begin
                            digit_cnt <= '0;
                            exec_eq   <= 1'b0;
                            op_next   <= key_to_op(key);
                            if (pending == OP_NONE) begin
                                prev    <= acc;
                                acc     <= '0;
                                pending <= key_to_op(key);
                            end
                        end
                    end
                end
`ifndef CALC_SEQ_FAST_MUL_EN
                ST_EXEC_MUL: begin
                    product <= prod_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + MC_W'(1);
                end
`endif
                default: ;
            endcase

            // The pending operator runs now; the key that triggered it is remembered in exec_eq/op_next.
            if (start_exec) begin
`ifdef CALC_SEQ_FAST_MUL_EN
                state <= ST_EXEC_ALU;
`else
                if (pending == OP_MUL) begin
                    state   <= ST_EXEC_MUL;
                    mcand   <= PROD_W'(prev[MUL_WIDTH-1:0]);
                    mplier  <= acc[MUL_WIDTH-1:0];
                    product <= '0;
                    mul_cnt <= '0;
                end else begin
                    state <= ST_EXEC_ALU;
                end
`endif
            end

            if (finish) begin
                state    <= ST_ENTRY;
                display  <= fin_result;
                overflow <= overflow | fin_ovf;
                if (exec_eq) begin
                    acc     <= fin_result;
                    pending <= OP_NONE;
                end else begin
                    prev    <= fin_result;
                    acc     <= '0;
                    pending <= op_next;
                end
            end
        end
    end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Controller that sequences the calculator datapath from a stream of 4-bit key codes.
- Accumulates decimal operands and holds a pending operator.
- Schedules a single-cycle add/sub unit or an iterative shift-add multiplier, in strict left-to-right order.
- Keeps a result-history stack for recall. Sits between the keypad decoder and the display driver.

Parameters:
- DEPTH, 8: history stack entries; power of 2.
- MUL_WIDTH, 16: multiplier operand width; also the multiply latency in cycles.
- MAX_DIGITS, 9: maximum digits accepted per operand.

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-low reset.
- key, input, 4: key code. 0-9 digit, 10 add, 11 sub, 12 mult, 13 equals, 14 recall, 15 clear.
- key_valid, input, 1: key presented.
- key_ready, output, 1: high only in ENTRY state. A key is accepted on an edge where key_valid & key_ready.
- display, output, 32: value to show.
- busy, output, 1: equals ~key_ready.
- overflow, output, 1: sticky arithmetic error flag.
- depth_used, output, log2(DEPTH)+1: number of valid stack entries.

Behaviour:
- Reset (reset==0 at an edge): state=ENTRY; acc, prev, display, overflow, depth_used, rd_ptr, digit_cnt=0; pending=NONE. Reset aborts any operation in flight, including a multiply.
- Registers: acc (entry operand), prev (left operand), pending (NONE/ADD/SUB/MUL), digit_cnt, stack[DEPTH], wr_ptr, rd_ptr.
- States: ENTRY, EXEC_ALU, EXEC_MUL.
- Digit, ENTRY:
  - If digit_cnt<MAX_DIGITS: acc<=acc*10+key (mod 2^32), digit_cnt++, display<=new acc.
  - Otherwise the key is accepted and discarded.
- Operator 10-12:
  - pending==NONE: prev<=acc; acc, digit_cnt<=0; pending<=key; no busy cycles.
  - Otherwise: go to EXEC_* for the old pending op. On completion prev<=result, display<=result, acc<=0, pending<=new op.
- Equals 13:
  - If pending!=NONE: execute; result goes to acc; pending<=NONE.
  - Then push the result (or acc, if nothing pending) to stack[wr_ptr]. wr_ptr++ wraps; depth_used saturates at DEPTH; the oldest entry is overwritten when full.
  - rd_ptr<=index of the newest entry; display<=result.
- Recall 14:
  - depth_used==0: acc<=0.
  - Otherwise: acc<=stack[rd_ptr]; rd_ptr steps to the next older valid entry, wrapping from oldest back to newest.
  - In both cases display<=acc; digit_cnt<=MAX_DIGITS, so further digits are ignored until an operator, equals or clear.
- Clear 15: acc, prev, display, overflow, digit_cnt<=0; pending<=NONE. Stack is retained.
- EXEC_ALU: 1 cycle.
  - ADD: overflow|=carry-out.
  - SUB: prev-acc, two's complement; overflow|=borrow.
- EXEC_MUL: MUL_WIDTH cycles of shift-add on prev[MUL_WIDTH-1:0]*acc[MUL_WIDTH-1:0], giving a 2*MUL_WIDTH-bit result.
  - overflow|=any nonzero operand bit above MUL_WIDTH.
- Latency: key_ready is low for exactly 1 cycle (ADD/SUB) or MUL_WIDTH cycles (MUL) after the accepting edge. Result and key_ready=1 are visible together.
- key_valid during busy: the key is held off by the source, not dropped.

Optional Feature:
- CALC_SEQ_FAST_MUL_EN defined: MUL uses a single-cycle combinational multiplier through EXEC_ALU. Busy is 1 cycle; the EXEC_MUL state is absent.
- Undefined: iterative multiplier, MUL_WIDTH busy cycles.

Test Plan:
- Keys 1,2,+,3,4,= -> display 12,12,3,34, then 46. No busy on +; busy exactly 1 cycle on =; depth_used=1.
- Keys 2,5,0,x,4,0,= -> key_ready low 16 cycles, display 10000, overflow 0. With CALC_SEQ_FAST_MUL_EN: low 1 cycle.
- Keys 5,-,7,= -> display 0xFFFFFFFE, overflow 1. Then 15 -> display 0, overflow 0.
- Keys 2,+,3,x,4,= -> 1 busy cycle on x (display 5), then 16 on =, display 20.
- Keys 1,=,2,=,3,=, then 14 x4 -> display 3,2,1,3 (wrap), depth_used=3. Ten digits 1..0 -> acc=123456789.
- reset=0 for one edge during cycle 8 of a multiply -> key_ready=1, display 0, depth_used 0. A following 14 yields 0.
